// File: rtl/encoder.sv
// Transmit-side odd-parity encoder: appends a parity MSB to each payload and buffers bytes in a small FIFO.
// Optional feature macro ENCODER_ERR_INJECT_EN adds err_inject, which stores even parity for the pushed byte.
module encoder #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-2:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_byte,
    input  logic                  out_ready,
    output logic [CNT_WIDTH-1:0]  tx_count
`ifdef ENCODER_ERR_INJECT_EN
    ,
    input  logic                  err_inject
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] EMPTY_C = CW'(0);

    function automatic logic odd_parity(input logic [DATA_WIDTH-2:0] d);
        return ~^d;
    endfunction

    logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [CW-1:0]         count_r;
    logic [CW-1:0]         count_nxt_s;
    logic [CNT_WIDTH-1:0]  tx_count_r;
    logic                  parity_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  in_ready_s;
    logic                  out_valid_s;

    // Flags come from the occupancy register only, so there is no ready/valid feed-through.
    always_comb begin
        in_ready_s  = (count_r != FULL_C);
        out_valid_s = (count_r != EMPTY_C);
        push_s      = in_valid && in_ready_s;
        pop_s       = out_valid_s && out_ready;
    end

    // Parity bit stored alongside the payload at push time.
    always_comb begin
`ifdef ENCODER_ERR_INJECT_EN
        parity_s = odd_parity(in_data) ^ err_inject;
`else
        parity_s = odd_parity(in_data);
`endif
    end

    // Occupancy next-state; simultaneous push and pop leaves it unchanged.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // FIFO storage; contents are not reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {parity_s, in_data};
        end
    end

    // Pointers, occupancy and transmitted-byte counter.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            tx_count_r <= {CNT_WIDTH{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r   <= rd_ptr_r + AW'(1);
                tx_count_r <= tx_count_r + CNT_WIDTH'(1);
            end
            count_r <= count_nxt_s;
        end
    end

    // Output drive; out_byte reads as zero while the FIFO is empty.
    always_comb begin
        in_ready  = in_ready_s;
        out_valid = out_valid_s;
        tx_count  = tx_count_r;
        if (out_valid_s) begin
            out_byte = mem_r[rd_ptr_r];
        end else begin
            out_byte = {DATA_WIDTH{1'b0}};
        end
    end

endmodule

// File: tb/tb_encoder.sv
// Scoreboard bench for encoder: the queue is the reference FIFO, filled on accepted pushes and drained on pops.
module tb_encoder;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CNTW  = 16;
`ifdef ENCODER_ERR_INJECT_EN
    localparam bit INJ = 1'b1;
`else
    localparam bit INJ = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            arst = 1'b1;
    logic            in_valid = 1'b0;
    logic [DW-2:0]   in_data = '0;
    logic            in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_byte;
    logic            out_ready = 1'b0;
    logic [CNTW-1:0] tx_count;
    logic            err_inject = 1'b0;

    logic [DW-1:0]   q[$];
    logic [CNTW-1:0] m_tx = '0;
    int              n_cmp = 0;
    int              n_mis = 0;

    always #5 clk = ~clk;

    encoder #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CNTW)) dut (
        .clk(clk), .arst(arst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_byte(out_byte), .out_ready(out_ready), .tx_count(tx_count)
`ifdef ENCODER_ERR_INJECT_EN
        , .err_inject(err_inject)
`endif
    );

    function automatic logic [DW-1:0] exp_byte();
        return (q.size() != 0) ? q[0] : 8'h00;
    endfunction

    // Drive one cycle from a negedge, update the reference model, return at the next negedge.
    task automatic drive_cycle(input logic v, input logic [DW-2:0] d, input logic r, input logic e);
        logic do_push, do_pop;
        logic [DW-1:0] junk;
        in_valid = v; in_data = d; out_ready = r; err_inject = e;
        do_push = v && (q.size() != DEPTH) && !arst;
        do_pop  = r && (q.size() != 0) && !arst;
        if (do_pop) begin junk = q.pop_front(); m_tx = m_tx + 16'd1; end
        if (do_push) q.push_back({(~^d) ^ (e & INJ), d});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && q.size() != 0; i++) begin
            n_cmp++; if (out_byte !== q[0]) begin n_mis++; $display("FAIL drain_byte actual=%h required=%h", out_byte, q[0]); end
            drive_cycle(1'b0, 7'h00, 1'b1, 1'b0);
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL drain_empty out_valid actual=%b required=0", out_valid); end
    endtask

    task automatic test_reset();
        @(negedge clk);
        q.delete(); m_tx = '0;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(i[0], 7'h2A, 1'b1, 1'b0);
            n_cmp++; if ({out_valid, out_byte, tx_count, in_ready} !== {1'b0, 8'h00, 16'h0000, 1'b1}) begin
                n_mis++; $display("FAIL reset_outputs actual v=%b b=%h c=%h r=%b required 0/00/0000/1", out_valid, out_byte, tx_count, in_ready);
            end
        end
        arst = 1'b0;
        drive_cycle(1'b0, 7'h00, 1'b1, 1'b0);
        drive_cycle(1'b0, 7'h00, 1'b1, 1'b0);
        n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL reset_release out_valid actual=%b required=0", out_valid); end
    endtask

    task automatic test_basic();
        drive_cycle(1'b1, 7'h00, 1'b1, 1'b0);
        n_cmp++; if (out_valid !== 1'b1 || out_byte !== 8'h80) begin n_mis++; $display("FAIL basic_first actual v=%b b=%h required 1/80", out_valid, out_byte); end
        drive_cycle(1'b1, 7'h7F, 1'b1, 1'b0);
        n_cmp++; if (out_valid !== 1'b1 || out_byte !== 8'h7F) begin n_mis++; $display("FAIL basic_second actual v=%b b=%h required 1/7f", out_valid, out_byte); end
        drive_cycle(1'b0, 7'h00, 1'b1, 1'b0);
        n_cmp++; if (tx_count !== 16'd2 || out_valid !== 1'b0) begin n_mis++; $display("FAIL basic_count actual c=%0d v=%b required 2/0", tx_count, out_valid); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (in_ready !== (q.size() != DEPTH)) begin n_mis++; $display("FAIL full_in_ready i=%0d actual=%b required=%b", i, in_ready, q.size() != DEPTH); end
            drive_cycle(1'b1, 7'(8'h10 + i), 1'b0, 1'b0);
        end
        n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_mis++; $display("FAIL full_flags actual r=%b v=%b required 0/1", in_ready, out_valid); end
        drive_cycle(1'b1, 7'h3C, 1'b1, 1'b0);
        n_cmp++; if (in_ready !== 1'b1 || out_byte !== 8'h91) begin n_mis++; $display("FAIL full_pop_refuse actual r=%b b=%h required 1/91", in_ready, out_byte); end
        drain();
        n_cmp++; if (tx_count !== m_tx || tx_count !== 16'd6) begin n_mis++; $display("FAIL full_tx_count actual=%0d required=6", tx_count); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] hold;
        drive_cycle(1'b1, 7'h21, 1'b0, 1'b0);
        drive_cycle(1'b1, 7'h22, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (out_byte !== q[0] || out_valid !== 1'b1 || in_ready !== 1'b1) begin
                n_mis++; $display("FAIL b2b i=%0d actual b=%h v=%b r=%b required %h/1/1", i, out_byte, out_valid, in_ready, q[0]);
            end
            drive_cycle(1'b1, 7'(8'h40 + 3 * i), 1'b1, 1'b0);
        end
        hold = q[0];
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 7'h00, 1'b0, 1'b0);
            n_cmp++; if (out_byte !== hold || out_valid !== 1'b1) begin n_mis++; $display("FAIL stall_hold actual b=%h v=%b required %h/1", out_byte, out_valid, hold); end
        end
        drain();
    endtask

    task automatic test_all_payloads();
        for (int p = 0; p < 128; p++) begin
            drive_cycle(1'b1, 7'(p), 1'b1, 1'b0);
            n_cmp++; if (out_valid !== 1'b1 || out_byte !== q[0] || (~^out_byte) !== 1'b0) begin
                n_mis++; $display("FAIL payload p=%0d actual b=%h v=%b required %h/1 err=0", p, out_byte, out_valid, q[0]);
            end
        end
        drain();
`ifdef ENCODER_ERR_INJECT_EN
        drive_cycle(1'b1, 7'h55, 1'b0, 1'b1);
        n_cmp++; if (out_byte !== 8'h55 || (~^out_byte) !== 1'b1) begin n_mis++; $display("FAIL inject actual=%h required=55", out_byte); end
        drive_cycle(1'b1, 7'h55, 1'b1, 1'b0);
        n_cmp++; if (out_byte !== 8'hD5) begin n_mis++; $display("FAIL inject_next actual=%h required=d5", out_byte); end
        drain();
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            n_cmp++; if (out_valid !== (q.size() != 0) || in_ready !== (q.size() != DEPTH) || out_byte !== exp_byte()) begin
                n_mis++; $display("FAIL random i=%0d actual v=%b r=%b b=%h required %b/%b/%h", i, out_valid, in_ready, out_byte, q.size() != 0, q.size() != DEPTH, exp_byte());
            end
            drive_cycle(1'($urandom_range(0, 1)), 7'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain();
        n_cmp++; if (tx_count !== m_tx) begin n_mis++; $display("FAIL random_tx_count actual=%0d required=%0d", tx_count, m_tx); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 7'(8'h30 + i), 1'b0, 1'b0);
        arst = 1'b1;
        #1;
        q.delete(); m_tx = '0;
        n_cmp++; if ({out_valid, out_byte, tx_count, in_ready} !== {1'b0, 8'h00, 16'h0000, 1'b1}) begin
            n_mis++; $display("FAIL midreset_async actual v=%b b=%h c=%h r=%b required 0/00/0000/1", out_valid, out_byte, tx_count, in_ready);
        end
        drive_cycle(1'b1, 7'h33, 1'b1, 1'b0);
        arst = 1'b0;
        drive_cycle(1'b0, 7'h00, 1'b1, 1'b0);
        drive_cycle(1'b0, 7'h00, 1'b1, 1'b0);
        n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL midreset_idle out_valid actual=%b required=0", out_valid); end
        drive_cycle(1'b1, 7'h01, 1'b0, 1'b0);
        n_cmp++; if (out_valid !== 1'b1 || out_byte !== 8'h01) begin n_mis++; $display("FAIL midreset_push actual v=%b b=%h required 1/01", out_valid, out_byte); end
        drive_cycle(1'b0, 7'h00, 1'b1, 1'b0);
        n_cmp++; if (out_valid !== 1'b0 || tx_count !== 16'd1) begin n_mis++; $display("FAIL midreset_after actual v=%b c=%0d required 0/1", out_valid, tx_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_back_to_back();
        test_all_payloads();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
